// File: rtl/dm_bus_arbiter_if.sv
// rtl/dm_bus_arbiter_if.sv - requester-side bus between one master and the data-memory arbiter
interface dm_bus_arbiter_if;
  logic        req;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        gnt;
  logic [31:0] rdata;

  modport master (output req, lock, addr, wdata, byteen, input gnt, rdata);
  modport slave  (input req, lock, addr, wdata, byteen, output gnt, rdata);
endinterface

// File: rtl/dm_bus_arbiter.sv
// rtl/dm_bus_arbiter.sv - same-cycle arbiter sharing the data-memory port between CPU (m0) and DMA (m1)
// Optional round-robin tie-break when DM_ARB_ROUND_ROBIN_EN is defined.
module dm_bus_arbiter #(
  parameter int DEPTH_WORDS = 4096,
  parameter int MAX_BURST   = 8
) (
  input  logic                clk,
  input  logic                reset,
  dm_bus_arbiter_if.slave     m0,
  dm_bus_arbiter_if.slave     m1,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_byteen,
  input  logic [31:0]         mem_rdata,
  output logic                addr_err
);

  typedef enum logic [1:0] {IDLE, M0, M1} owner_t;

  localparam logic [7:0]  MAX_B   = 8'(MAX_BURST);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  owner_t      owner_q, owner_d;
  logic [7:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        lock_hold;
  logic        sel_m1;
  logic        grant_any;
  logic        gnt0, gnt1;
  logic        oor;
  logic [31:0] sel_addr;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;
`endif

  always_comb begin
    lock_hold = (owner_q == M1) && m1.req && m1.lock && (burst_q < MAX_B);
    sel_m1    = 1'b0;
    if (lock_hold) begin
      sel_m1 = 1'b1;
    end else if (m0.req && m1.req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      // An exhausted burst always hands the port back to the CPU.
      sel_m1 = rr_q && (burst_q != MAX_B);
`else
      sel_m1 = 1'b0;
`endif
    end else begin
      sel_m1 = m1.req;
    end

    // Reset gates the grants so an in-flight write can never commit.
    grant_any = (m0.req || m1.req) && reset;
    gnt0      = grant_any && !sel_m1;
    gnt1      = grant_any && sel_m1;

    sel_addr   = sel_m1 ? m1.addr : m0.addr;
    oor        = (sel_addr >> 2) >= DEPTH_W;
    mem_addr   = {sel_addr[31:2], 2'b00};
    mem_wdata  = sel_m1 ? m1.wdata : m0.wdata;
    mem_byteen = (grant_any && !oor) ? (sel_m1 ? m1.byteen : m0.byteen) : 4'h0;

    m0.gnt   = gnt0;
    m1.gnt   = gnt1;
    m0.rdata = (gnt0 && !oor) ? mem_rdata : 32'h0;
    m1.rdata = (gnt1 && !oor) ? mem_rdata : 32'h0;

    owner_d = gnt0 ? M0 : (gnt1 ? M1 : IDLE);
    burst_d = 8'h00;
    if (gnt1 && m1.lock) begin
      if (owner_q == M1) burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
      else               burst_d = 8'h01;
    end
    err_d = grant_any && oor;
`ifdef DM_ARB_ROUND_ROBIN_EN
    rr_d = rr_q;
    if (gnt0) rr_d = 1'b1;
    if (gnt1) rr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= IDLE;
      burst_q <= 8'h00;
      err_q   <= 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      err_q   <= err_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign addr_err = err_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb/tb_dm_bus_arbiter.sv - self-checking bench for dm_bus_arbiter with a behavioural reference model
module tb_dm_bus_arbiter;
  localparam int DEPTH = 4096;
  localparam int MAXB  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_bus_arbiter_if m0_if();
  dm_bus_arbiter_if m1_if();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        addr_err;

  dm_bus_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .m0(m0_if.slave), .m1(m1_if.slave),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  logic [31:0] mem    [0:4095];
  logic [31:0] shadow [0:4095];

  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: who won last cycle, how long m1 has held a locked run, tie-break pointer.
  int          m_last = 0, m_run = 0;
  bit          m_rr = 0, m_err = 0;
  int          n_last, n_run;
  bit          n_rr, n_err, n_we;
  int          n_word;
  logic [31:0] n_wdata;
  logic [3:0]  n_be;

  always @(negedge clk) begin : model_cmp
    int w;
    bit hold, oor;
    logic [31:0] a, wd, er;
    logic [3:0] be;
    n_we = 0; n_word = 0; n_wdata = 0; n_be = 0;
    if (!reset) begin
      check("rst_m0_gnt", {31'b0, m0_if.gnt}, 32'd0);
      check("rst_m1_gnt", {31'b0, m1_if.gnt}, 32'd0);
      check("rst_byteen", {28'b0, mem_byteen}, 32'd0);
      check("rst_addr_err", {31'b0, addr_err}, 32'd0);
      n_last = 0; n_run = 0; n_rr = 0; n_err = 0;
    end else begin
      hold = (m_last == 2) && m1_if.req && m1_if.lock && (m_run < MAXB);
      if (hold) w = 2;
      else if (m0_if.req && m1_if.req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        w = (m_run >= MAXB) ? 1 : (m_rr ? 2 : 1);
`else
        w = 1;
`endif
      end
      else if (m0_if.req) w = 1;
      else if (m1_if.req) w = 2;
      else w = 0;
      a   = (w == 2) ? m1_if.addr   : m0_if.addr;
      wd  = (w == 2) ? m1_if.wdata  : m0_if.wdata;
      be  = (w == 2) ? m1_if.byteen : m0_if.byteen;
      oor = (a / 4) >= DEPTH;
      er  = (w != 0 && !oor) ? shadow[a[13:2]] : 32'h0;
      if (w == 0 || oor) be = 4'h0;
      check("m0_gnt", {31'b0, m0_if.gnt}, {31'b0, (w == 1)});
      check("m1_gnt", {31'b0, m1_if.gnt}, {31'b0, (w == 2)});
      check("mem_byteen", {28'b0, mem_byteen}, {28'b0, be});
      check("m0_rdata", m0_if.rdata, (w == 1) ? er : 32'h0);
      check("m1_rdata", m1_if.rdata, (w == 2) ? er : 32'h0);
      check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
      if (w != 0) begin
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_wdata", mem_wdata, wd);
      end
      n_last = w;
      if (w == 2 && m1_if.lock) n_run = (m_last == 2) ? ((m_run >= 255) ? 255 : m_run + 1) : 1;
      else n_run = 0;
      n_rr  = (w == 1) ? 1'b1 : (w == 2) ? 1'b0 : m_rr;
      n_err = (w != 0) && oor;
      n_we = (be != 4'h0); n_word = int'(a[13:2]); n_wdata = wd; n_be = be;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_last <= 0; m_run <= 0; m_rr <= 0; m_err <= 0;
    end else begin
      m_last <= n_last; m_run <= n_run; m_rr <= n_rr; m_err <= n_err;
      if (n_we)
        for (int b = 0; b < 4; b++)
          if (n_be[b]) shadow[n_word][8*b +: 8] <= n_wdata[8*b +: 8];
    end
  end

  task automatic set_in(input bit r0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                        input bit r1, input bit l1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic [3:0] b1);
    m0_if.req = r0; m0_if.lock = 1'b0; m0_if.addr = a0; m0_if.wdata = d0; m0_if.byteen = b0;
    m1_if.req = r1; m1_if.lock = l1;   m1_if.addr = a1; m1_if.wdata = d1; m1_if.byteen = b1;
  endtask

  task automatic drive(input bit r0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                       input bit r1, input bit l1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [3:0] b1);
    @(posedge clk); #1;
    set_in(r0, a0, d0, b0, r1, l1, a1, d1, b1);
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int m1_cnt;
  bit exp_m1;

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // A request under reset must not be granted or write.
    drive(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    check("lit_rst_gnt", {31'b0, m0_if.gnt}, 32'd0);
    check("lit_rst_be", {28'b0, mem_byteen}, 32'd0);
    idle();
    @(posedge clk); #1; reset = 1'b1;

    drive(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    check("lit_wr_gnt", {31'b0, m0_if.gnt}, 32'd1);
    check("lit_wr_addr", mem_addr, 32'h10);
    check("lit_wr_be", {28'b0, mem_byteen}, 32'hF);
    drive(1, 32'h10, 0, 4'h0, 0, 0, 0, 0, 0);
    check("lit_rd_data", m0_if.rdata, 32'hDEADBEEF);

    // Contention without lock; m1-only cycle first leaves the tie-break at m0.
    drive(0, 0, 0, 0, 1, 0, 32'h40, 0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h10, 0, 4'h0, 1, 0, 32'h40, 0, 4'h0);
`ifdef DM_ARB_ROUND_ROBIN_EN
      exp_m1 = (i % 2) == 1;
`else
      exp_m1 = 1'b0;
`endif
      check("lit_both_m0", {31'b0, m0_if.gnt}, {31'b0, !exp_m1});
      check("lit_both_m1", {31'b0, m1_if.gnt}, {31'b0, exp_m1});
    end
    idle();

    // Locked burst: m1 alone, then CPU waits at most MAX_BURST cycles.
    m1_cnt = 0;
    drive(0, 0, 0, 0, 1, 1, 32'h100, 0, 4'h0);
    m1_cnt += int'(m1_if.gnt);
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h10, 0, 4'h0, 1, 1, 32'h100, 0, 4'h0);
      m1_cnt += int'(m1_if.gnt);
    end
    check("lit_burst_len", m1_cnt, 32'd8);
    drive(1, 32'h10, 0, 4'h0, 1, 1, 32'h100, 0, 4'h0);
    check("lit_yield_m0", {31'b0, m0_if.gnt}, 32'd1);
    check("lit_yield_m1", {31'b0, m1_if.gnt}, 32'd0);
    idle();

    // Partial-byte DMA write under lock while the CPU waits.
    drive(0, 0, 0, 0, 1, 1, 32'h200, 0, 4'h0);
    drive(1, 32'h10, 0, 4'h0, 1, 1, 32'h22, 32'h0000ABCD, 4'b0011);
    check("lit_dma_addr", mem_addr, 32'h20);
    check("lit_dma_be", {28'b0, mem_byteen}, 32'h3);
    check("lit_dma_m0gnt", {31'b0, m0_if.gnt}, 32'd0);
    check("lit_dma_m0rd", m0_if.rdata, 32'h0);
    drive(1, 32'h20, 0, 4'h0, 0, 0, 0, 0, 0);
    check("lit_dma_rb", m0_if.rdata, 32'h0000ABCD);

    // Out-of-range word 4096.
    drive(1, 32'h4000, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0);
    check("lit_oor_gnt", {31'b0, m0_if.gnt}, 32'd1);
    check("lit_oor_be", {28'b0, mem_byteen}, 32'h0);
    check("lit_oor_rd", m0_if.rdata, 32'h0);
    check("lit_oor_err0", {31'b0, addr_err}, 32'd0);
    idle();
    check("lit_oor_err1", {31'b0, addr_err}, 32'd1);
    idle();
    check("lit_oor_err2", {31'b0, addr_err}, 32'd0);

    // Reset asserted on cycle 4 of a burst with a write pending.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 1, 32'h80, 0, 4'h0);
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 1, 1, 32'h80, 32'h12345678, 4'hF);
    reset = 1'b0;
    #1;
    check("lit_mrst_gnt", {31'b0, m1_if.gnt}, 32'd0);
    check("lit_mrst_be", {28'b0, mem_byteen}, 32'd0);
    @(posedge clk); #1;
    check("lit_mrst_mem", mem[32], 32'h0);
    set_in(1, 32'h10, 0, 4'h0, 1, 1, 32'h80, 32'h12345678, 4'hF);
    reset = 1'b1;
    @(negedge clk); #1;
    check("lit_post_m0", {31'b0, m0_if.gnt}, 32'd1);
    check("lit_post_m1", {31'b0, m1_if.gnt}, 32'd0);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
